siso_bist_sequencer: RTL and testbench
======================================

// Module: siso_bist_sequencer
// PURPOSE
//  Built-in self-test sequencer for the SISO shift-register datapath. Generates a
//  PRBS-8 stimulus bit stream into the SISO input mux, waits out the chain latency,
//  then compares the chain output against a delayed replica of the stimulus.
//  Reports pass/fail, error count and first-error index. Sits beside LFSR8 at top level.
// PARAMETERS
//  LATENCY    10     cycles from STIM_BIT sampled to same bit on SISO_OUT (2..255)
//  CHECK_LEN  255    number of compared bits per run (1..65535)
//  ERR_W      8      ERR_COUNT width; count saturates at 2^ERR_W-1
//  SEED       8'h01  PRBS start state; SEED==0 is replaced by 8'h01 (no lockup)
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RESET          in   1      synchronous, active-high; overrides every other input
//  START          in   1      level-sampled; launches a run when in IDLE
//  ABORT          in   1      cancels a run in progress
//  SISO_OUT       in   1      serial output of the SISO chain
//  STIM_EN        out  1      1 = SISO input mux must select STIM_BIT
//  STIM_BIT       out  1      PRBS stimulus bit
//  BUSY           out  1      1 in FILL and CHECK
//  DONE           out  1      one-cycle pulse at end of a complete run
//  PASS           out  1      1 = last complete run had zero errors; held until next START
//  ERR_COUNT      out  ERR_W  mismatches of last/current run, saturating
//  FIRST_ERR_IDX  out  16     compare index (0-based) of first mismatch; 16'hFFFF if none
// BEHAVIOUR
//  - PRBS: 8-bit Fibonacci, shift left, fb = s[7]^s[5]^s[4]^s[3] into s[0]; out = s[7];
//    period 255. Two instances: STIM (drives STIM_BIT) and EXP (expected bit).
//  - Reset: state IDLE; STIM_EN, STIM_BIT, BUSY, DONE, PASS = 0; ERR_COUNT = 0;
//    FIRST_ERR_IDX = 16'hFFFF; STIM = EXP = SEED; counters = 0.
//  - States: IDLE -> FILL -> CHECK -> DONE -> IDLE.
//  - IDLE: START=1 & ABORT=0 -> FILL next cycle; STIM, EXP reload SEED; ERR_COUNT := 0;
//    PASS := 0; FIRST_ERR_IDX := FFFF; cycle counter := 0. START&ABORT together: stay IDLE.
//  - FILL: STIM_EN=1, BUSY=1; STIM steps every cycle; EXP holds. After exactly LATENCY
//    FILL cycles -> CHECK (counter reaches LATENCY-1 then transitions).
//  - CHECK: STIM keeps stepping; each cycle compare SISO_OUT vs EXP out, then EXP steps.
//    Mismatch: ERR_COUNT += 1 unless saturated; if FIRST_ERR_IDX==FFFF, record compare
//    index. After CHECK_LEN compares -> DONE.
//  - DONE (one cycle): DONE=1, STIM_EN=0, BUSY=0, PASS := (ERR_COUNT==0) including any
//    mismatch on the final compare. Next cycle IDLE; START held high relaunches then.
//  - ABORT=1 in FILL/CHECK: IDLE next cycle; no DONE pulse; PASS stays 0; ERR_COUNT and
//    FIRST_ERR_IDX hold; compare in the abort cycle is discarded. ABORT in IDLE/DONE: ignored.
//  - START while BUSY or DONE: ignored.
//  - STIM_BIT valid only while STIM_EN=1; driven 0 otherwise.
//  - RESET mid-run: full reset state next edge; no DONE.
//  - Run length: START edge to DONE pulse = 1 + LATENCY + CHECK_LEN cycles.
// TESTING
//  1. Ideal chain model (LATENCY-cycle delay of STIM_BIT), START 1 cycle -> BUSY high
//     265 cycles, DONE at cycle 266, PASS=1, ERR_COUNT=0, FIRST_ERR_IDX=FFFF.
//  2. SISO_OUT stuck at 0 -> ERR_COUNT=128 (ones in 255-bit PRBS), PASS=0, FIRST_ERR_IDX=7.
//  3. Ideal model with single inverted bit at compare index 100 -> ERR_COUNT=1,
//     FIRST_ERR_IDX=100, PASS=0.
//  4. ERR_W=4, SISO_OUT = inverted ideal -> ERR_COUNT saturates at 15, PASS=0.
//  5. ABORT at CHECK cycle 50 -> BUSY=0 next cycle, no DONE, ERR_COUNT held; new START
//     then runs as scenario 1 with PASS=1.
//  6. RESET in FILL cycle 3, START & ABORT together in IDLE -> all outputs reset values,
//     state stays IDLE, STIM_EN=0.

Source files
------------

// File: rtl/siso_bist_sequencer.sv
// siso_bist_sequencer: BIST sequencer for the SISO shift-register datapath.
// It feeds a PRBS-8 stream into the chain and waits out the chain latency.
// It then compares the chain output against a replica PRBS that starts LATENCY
// cycles later, and reports the result as pass/fail, an error count and the
// index of the first error.
module siso_bist_sequencer #(
    parameter int          LATENCY   = 10,
    parameter int          CHECK_LEN = 255,
    parameter int          ERR_W     = 8,
    parameter logic [7:0]  SEED      = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             siso_out,
    output logic             stim_en,
    output logic             stim_bit,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [15:0]      LAT_LAST = 16'(LATENCY - 1);
    localparam logic [15:0]      CHK_LAST = 16'(CHECK_LEN - 1);
    localparam logic [15:0]      NO_ERR   = 16'hFFFF;
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1'b1);
    localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

    // The sequence is an 8-bit Fibonacci LFSR that shifts left.
    // Feedback is s7^s5^s4^s3, the output bit is s[7], and the period is 255.
    function automatic logic [7:0] prbs_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       stim_r, stim_s;
    logic [7:0]       exp_r, exp_s;
    logic [15:0]      cnt_r, cnt_s;
    logic [ERR_W-1:0] err_r, err_s;
    logic [15:0]      first_r, first_s;
    logic             pass_r, pass_s;
    logic             active_s;
    logic             stim_en_r, stim_bit_r, busy_r, done_r;

    // Next-state, datapath updates and the next values of the registered outputs.
    always_comb begin
        state_s = state_r;
        stim_s  = stim_r;
        exp_s   = exp_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        first_s = first_r;
        pass_s  = pass_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_FILL;
                    stim_s  = SEED_EFF;
                    exp_s   = SEED_EFF;
                    cnt_s   = 16'd0;
                    err_s   = ERR_ZERO;
                    first_s = NO_ERR;
                    pass_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    stim_s = prbs_step(stim_r);
                    if (cnt_r == LAT_LAST) begin
                        state_s = ST_CHECK;
                        cnt_s   = 16'd0;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    // The compare in the abort cycle is dropped.
                    state_s = ST_IDLE;
                end else begin
                    stim_s = prbs_step(stim_r);
                    exp_s  = prbs_step(exp_r);
                    if (siso_out != exp_r[7]) begin
                        if (err_r != ERR_MAX) begin
                            err_s = err_r + ERR_ONE;
                        end else begin
                            err_s = err_r;
                        end
                        if (first_r == NO_ERR) begin
                            first_s = cnt_r;
                        end else begin
                            first_s = first_r;
                        end
                    end else begin
                        err_s   = err_r;
                        first_s = first_r;
                    end
                    if (cnt_r == CHK_LAST) begin
                        state_s = ST_DONE;
                        cnt_s   = 16'd0;
                        // The verdict includes a mismatch on the final compare.
                        pass_s  = (err_s == ERR_ZERO);
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        active_s = (state_s == ST_FILL) || (state_s == ST_CHECK);
    end

    // The state, the datapath and all outputs are registered.
    // Reset is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            stim_r     <= SEED_EFF;
            exp_r      <= SEED_EFF;
            cnt_r      <= 16'd0;
            err_r      <= ERR_ZERO;
            first_r    <= NO_ERR;
            pass_r     <= 1'b0;
            stim_en_r  <= 1'b0;
            stim_bit_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            stim_r     <= stim_s;
            exp_r      <= exp_s;
            cnt_r      <= cnt_s;
            err_r      <= err_s;
            first_r    <= first_s;
            pass_r     <= pass_s;
            stim_en_r  <= active_s;
            stim_bit_r <= active_s & stim_s[7];
            busy_r     <= active_s;
            done_r     <= (state_s == ST_DONE);
        end
    end

    assign stim_en       = stim_en_r;
    assign stim_bit      = stim_bit_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = first_r;

endmodule

// File: tb/tb_siso_bist_sequencer.sv
// tb_siso_bist_sequencer: directed bench for the SISO BIST sequencer.
// One instance uses an 8-bit error count and one uses a 4-bit error count.
// The ideal chain is modelled as a LATENCY-deep delay of STIM_BIT.
module tb_siso_bist_sequencer;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic        siso, siso4;
    logic        stim_en, stim_bit, busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] first_err_idx;
    logic        stim_en4, stim_bit4, busy4, done4, pass4;
    logic [3:0]  err_count4;
    logic [15:0] first_err_idx4;

    logic [LAT-1:0] chain_r  = '0;
    logic [LAT-1:0] chain4_r = '0;
    int bcnt = 0;
    int mode, flip_a, flip_b;
    int n_tests = 0;
    int n_fail  = 0;
    int busy_cyc, done_cyc, n_done;

    siso_bist_sequencer #(.LATENCY(LAT), .CHECK_LEN(255), .ERR_W(8), .SEED(8'h01)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .siso_out(siso),
        .stim_en(stim_en), .stim_bit(stim_bit), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    siso_bist_sequencer #(.LATENCY(LAT), .CHECK_LEN(255), .ERR_W(4), .SEED(8'h01)) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .siso_out(siso4),
        .stim_en(stim_en4), .stim_bit(stim_bit4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err_count4), .first_err_idx(first_err_idx4)
    );

    always #5 clk = ~clk;

    // The chain delay lines, plus a counter of busy cycles (0 in the first FILL cycle).
    always @(posedge clk) begin
        chain_r  <= {chain_r[LAT-2:0], stim_bit};
        chain4_r <= {chain4_r[LAT-2:0], stim_bit4};
        bcnt     <= busy ? bcnt + 1 : 0;
    end

    // SISO_OUT fault model.
    // Mode 0 is ideal, mode 1 is stuck at 0, mode 2 flips the compare indices
    // flip_a and flip_b, and mode 3 is the inverted ideal output.
    always_comb begin
        case (mode)
            1:       siso = 1'b0;
            2:       siso = chain_r[LAT-1] ^ ((bcnt == LAT + flip_a) || (bcnt == LAT + flip_b));
            3:       siso = ~chain_r[LAT-1];
            default: siso = chain_r[LAT-1];
        endcase
        siso4 = ~chain4_r[LAT-1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pulses START for one cycle, then waits for DONE.
    // On return the bench is in the DONE cycle, or done_cyc is -1 on timeout.
    task automatic run_to_done(output int bc, output int dc);
        bc = 0;
        dc = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (done) begin
                dc = i;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_bcnt(input int target);
        int found;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            if (bcnt == target) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("wait_bcnt", found, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_stim_en"},  32'(stim_en), 32'd0);
        check_eq({tag, "_stim_bit"}, 32'(stim_bit), 32'd0);
        check_eq({tag, "_busy"},     32'(busy), 32'd0);
        check_eq({tag, "_done"},     32'(done), 32'd0);
        check_eq({tag, "_pass"},     32'(pass), 32'd0);
        check_eq({tag, "_err"},      32'(err_count), 32'd0);
        check_eq({tag, "_first"},    32'(first_err_idx), 32'hFFFF);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 0; flip_a = 9999; flip_b = 9999;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Scenario 1: ideal chain.
        run_to_done(busy_cyc, done_cyc);
        check_eq("s1_busy_cycles", busy_cyc, 265);
        check_eq("s1_done_cycle", done_cyc, 266);
        check_eq("s1_err", 32'(err_count), 32'd0);
        check_eq("s1_first", 32'(first_err_idx), 32'hFFFF);
        @(negedge clk);
        check_eq("s1_pass", 32'(pass), 32'd1);
        check_eq("s1_done_low", 32'(done), 32'd0);

        // Scenario 3: single inverted bit at compare index 100.
        mode = 2; flip_a = 100; flip_b = 9999;
        run_to_done(busy_cyc, done_cyc);
        check_eq("s3_done_cycle", done_cyc, 266);
        check_eq("s3_err", 32'(err_count), 32'd1);
        check_eq("s3_first", 32'(first_err_idx), 32'd100);
        @(negedge clk);
        check_eq("s3_pass", 32'(pass), 32'd0);

        // Scenario 2: SISO_OUT stuck at 0.
        mode = 1;
        run_to_done(busy_cyc, done_cyc);
        check_eq("s2_done_cycle", done_cyc, 266);
        check_eq("s2_err", 32'(err_count), 32'd128);
        check_eq("s2_first", 32'(first_err_idx), 32'd7);
        @(negedge clk);
        check_eq("s2_pass", 32'(pass), 32'd0);

        // Scenario 4: the inverted chain saturates the 4-bit count.
        // The 8-bit count reaches 255.
        mode = 3;
        run_to_done(busy_cyc, done_cyc);
        check_eq("s4_done_cycle", done_cyc, 266);
        check_eq("s4_err8", 32'(err_count), 32'd255);
        check_eq("s4_err4", 32'(err_count4), 32'd15);
        check_eq("s4_first4", 32'(first_err_idx4), 32'd0);
        @(negedge clk);
        check_eq("s4_pass4", 32'(pass4), 32'd0);

        // Scenario 5: abort in CHECK cycle 50.
        // Compare indices 10 and 50 are both corrupted, and the abort-cycle
        // compare must be dropped.
        mode = 2; flip_a = 10; flip_b = 50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bcnt(LAT + 50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("s5_busy", 32'(busy), 32'd0);
        check_eq("s5_stim_en", 32'(stim_en), 32'd0);
        check_eq("s5_err_held", 32'(err_count), 32'd1);
        check_eq("s5_first_held", 32'(first_err_idx), 32'd10);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check_eq("s5_no_done", n_done, 0);
        check_eq("s5_pass", 32'(pass), 32'd0);
        check_eq("s5_err_still", 32'(err_count), 32'd1);
        mode = 0;
        run_to_done(busy_cyc, done_cyc);
        check_eq("s5_rerun_done_cycle", done_cyc, 266);
        check_eq("s5_rerun_err", 32'(err_count), 32'd0);
        @(negedge clk);
        check_eq("s5_rerun_pass", 32'(pass), 32'd1);

        // Scenario 6: reset in FILL cycle 3, then START and ABORT together in IDLE.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bcnt(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("s6_rst");
        start = 1'b1;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("s6_sa");
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
